// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
// A prefetch entry pairs an instruction with the PC it was fetched from.
package mips_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Bundles the instruction-memory request/response bus and the IF/ID output handshake.
// master = fetch unit; slave = memory plus IF/ID register side.
interface if_prefetch_unit_if;
  import mips_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc_plus4;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc_plus4
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc_plus4
  );

endinterface

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous circular FIFO with occupancy count; clear has priority over push/pop.
// Head data is read combinationally, so a push becomes visible the cycle after it.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: issues word fetches under a credit limit, buffers
// in-order responses, and drops responses still in flight when a redirect lands.
module if_prefetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  if_prefetch_unit_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fire;
  logic            drop;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [$bits(fetch_entry_t)-1:0] fifo_dout;

  // Buffered plus outstanding words may never exceed the FIFO size, so every
  // response has a slot waiting for it.
  assign credit_used  = {1'b0, fifo_count} + {1'b0, inflight};
  assign bus.imem_req = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_addr = fetch_pc;

  assign fire = bus.imem_req && bus.imem_gnt;
  assign drop = (drop_cnt != '0);
  assign push = bus.imem_rvalid && !drop && !redirect;
  assign pop  = bus.out_valid && bus.out_ready && !redirect;

  assign push_entry = '{inst: bus.imem_rdata, pc: resp_pc};
  assign head       = fetch_entry_t'(fifo_dout);

  assign bus.out_valid    = !fifo_empty;
  assign bus.out_inst     = head.inst;
  assign bus.out_pc_plus4 = head.pc + PC_INC;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (push_entry),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      // A response arriving in the redirect cycle is already accounted for;
      // only those still to come must be discarded.
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      inflight <= inflight - CW'(bus.imem_rvalid);
      drop_cnt <= inflight - CW'(bus.imem_rvalid);
    end else begin
      if (fire) fetch_pc <= fetch_pc + PC_INC;
      if (push) resp_pc  <= resp_pc + PC_INC;
      inflight <= inflight + CW'(fire) - CW'(bus.imem_rvalid);
      if (bus.imem_rvalid && drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (drop_cnt <= inflight && inflight <= CW'(DEPTH));
      assert (!(push && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: variable-latency in-order memory model plus a
// scoreboard of expected {inst, pc+4} pushed on each grant and popped on output.
module tb_if_prefetch_unit;
  import mips_fetch_pkg::*;

  localparam int unsigned     DEPTH    = 4;
  localparam logic [31:0]     RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;

  if_prefetch_unit_if bus();

  if_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } resp_t;

  resp_t        pend[$];
  fetch_entry_t expq[$];

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned n_grant = 0;
  int unsigned n_pop = 0;
  logic        gnt_en;
  logic        obs_req;
  logic        obs_valid;
  logic [31:0] obs_addr;
  logic [31:0] last_pop_pc4;
  logic [31:0] last_pop_inst;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h2400_0000;
  endfunction

  // One clock cycle: drive at negedge, observe #1 later, advance to next negedge.
  task automatic tick();
    resp_t        r;
    fetch_entry_t e;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (rst) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = r.data;
    end
    bus.imem_gnt = gnt_en;
    #1;
    obs_req   = bus.imem_req;
    obs_addr  = bus.imem_addr;
    obs_valid = bus.out_valid;
    if (bus.imem_req && bus.imem_gnt) begin
      r.due  = cyc + lat;
      r.data = memfn(bus.imem_addr);
      pend.push_back(r);
      e.inst = memfn(bus.imem_addr);
      e.pc   = bus.imem_addr + 32'd4;
      expq.push_back(e);
      n_grant++;
    end
    if (bus.out_valid && bus.out_ready && !redirect && !rst) begin
      n_pop++;
      checks++;
      last_pop_pc4  = bus.out_pc_plus4;
      last_pop_inst = bus.out_inst;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL stream_extra: got pc_plus4=%h inst=%h, expected no output", bus.out_pc_plus4, bus.out_inst);
      end else begin
        e = expq.pop_front();
        if (bus.out_pc_plus4 !== e.pc || bus.out_inst !== e.inst) begin
          failures++;
          $display("FAIL stream_order: got pc_plus4=%h inst=%h, expected pc_plus4=%h inst=%h",
                   bus.out_pc_plus4, bus.out_inst, e.pc, e.inst);
        end
      end
    end
    if (redirect || rst) expq.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; bus.out_ready = 1'b1; gnt_en = 1'b1; lat = 1;
    tick();
    tick();
    checks++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_held: req=%b valid=%b, expected req=0 valid=0", obs_req, obs_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs_addr !== RESET_PC || obs_req !== 1'b1 || obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: addr=%h req=%b valid=%b, expected addr=%h req=1 valid=0",
               obs_addr, obs_req, obs_valid, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int unsigned p0;
    do_reset();
    lat = 1; gnt_en = 1'b1; bus.out_ready = 1'b1;
    p0 = n_pop;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'(i * 4)) begin
        failures++;
        $display("FAIL stream_addr[%0d]: req=%b addr=%h, expected req=1 addr=%h", i, obs_req, obs_addr, 32'(i * 4));
      end
    end
    checks++;
    if (n_pop - p0 != 18) begin
      failures++;
      $display("FAIL stream_rate: pops=%0d, expected 18", n_pop - p0);
    end
  endtask

  task automatic test_backpressure();
    int unsigned g0;
    int unsigned p0;
    do_reset();
    lat = 1; gnt_en = 1'b1; bus.out_ready = 1'b0;
    g0 = n_grant;
    for (int unsigned i = 0; i < 10; i++) tick();
    checks++;
    if (n_grant - g0 != DEPTH || obs_req !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit: grants=%0d req=%b, expected grants=%0d req=0", n_grant - g0, obs_req, DEPTH);
    end
    bus.out_ready = 1'b1;
    p0 = n_pop;
    for (int unsigned i = 0; i < 4; i++) tick();
    checks++;
    if (n_pop - p0 != 4 || last_pop_pc4 !== 32'h10) begin
      failures++;
      $display("FAIL bp_drain: pops=%0d last_pc_plus4=%h, expected pops=4 last_pc_plus4=00000010", n_pop - p0, last_pop_pc4);
    end
  endtask

  task automatic wait_first_pop(input logic [31:0] pc, input string name);
    int unsigned p0;
    int unsigned k;
    p0 = n_pop;
    k = 0;
    while (n_pop == p0 && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (n_pop == p0 || last_pop_pc4 !== pc + 32'd4 || last_pop_inst !== memfn(pc)) begin
      failures++;
      $display("FAIL %s_first: pops=%0d pc_plus4=%h inst=%h, expected a pop with pc_plus4=%h inst=%h",
               name, n_pop - p0, last_pop_pc4, last_pop_inst, pc + 32'd4, memfn(pc));
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 4; gnt_en = 1'b1; bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    tick();
    checks++;
    if (obs_addr !== 32'h100 || obs_req !== 1'b1) begin
      failures++;
      $display("FAIL redir_addr: addr=%h req=%b, expected addr=00000100 req=1", obs_addr, obs_req);
    end
    wait_first_pop(32'h100, "redir");
  endtask

  task automatic test_redirect_pop();
    do_reset();
    lat = 2; gnt_en = 1'b1; bus.out_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) tick();
    redirect = 1'b1; redirect_pc = 32'h400; bus.out_ready = 1'b1;
    tick();
    checks++;
    if (obs_valid !== 1'b1) begin
      failures++;
      $display("FAIL rpop_setup: valid=%b, expected 1", obs_valid);
    end
    redirect = 1'b0;
    tick();
    checks++;
    if (obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL rpop_flush: valid=%b, expected 0", obs_valid);
    end
    wait_first_pop(32'h400, "rpop");
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 2; gnt_en = 1'b1; bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 6; i++) tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    wait_first_pop(32'h300, "b2b");
  endtask

  task automatic test_mid_reset();
    do_reset();
    lat = 3; gnt_en = 1'b1; bus.out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) tick();
    gnt_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs_req !== 1'b0) begin
      failures++;
      $display("FAIL mrst_req: req=%b, expected 0", obs_req);
    end
    rst = 1'b0; gnt_en = 1'b1; bus.out_ready = 1'b1;
    tick();
    checks++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
      failures++;
      $display("FAIL mrst_release: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=%h",
               obs_valid, obs_req, obs_addr, RESET_PC);
    end
    wait_first_pop(RESET_PC, "mrst");
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    gnt_en = 1'b1;
    bus.out_ready = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_pop();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
